sd_acq_echo_sched: RTL
======================

Name: sd_acq_echo_sched

Overview:
- Sequences the spin-echo acquisition window for one CPMG train.
- Holds a small config bank loaded over the 4-bit select / 16-bit data / load-strobe bus.
- Arms on the first-pulse marker, then opens one acquisition window per 180° refocusing marker after a programmed delay.
- Drives the acquisition-enable into the SD acquisition datapath and reports echo index, busy, done and overrun.

Parameters:
- CNT_W, 16, width of delay/window counters and config fields.
- ECHO_W, 12, width of echo count and echo index.
- TMO_CYC, 1000000, ARMED watchdog limit in clk_sys cycles (used only with ACQ_TIMEOUT_EN).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_load  in  1  single-cycle strobe; writes cfg_data to the register selected by cfg_sel.
- cfg_sel  in  4  0 = delay, 1 = window, 2 = echo_num, 3 = ctrl; 4..15 ignored.
- cfg_data  in  CNT_W  config write data.
- start  in  1  one-cycle train-start marker (90° pulse).
- echo_trig  in  1  one-cycle 180° pulse marker.
- abort  in  1  one-cycle cancel.
- acq_en  out  1  acquisition window enable to the datapath.
- echo_idx  out  ECHO_W  completed-echo count in the current train.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the train completes.
- ovr_err  out  1  sticky; echo_trig arrived while a window or delay was pending.

Behaviour:
- Reset (sync, rst=1): state IDLE; acq_en=0, echo_idx=0, busy=0, done=0, ovr_err=0; delay=0, window=16, echo_num=1, ctrl=0.
- Config writes accepted only in IDLE; writes while busy are ignored. echo_num takes cfg_data[ECHO_W-1:0]. ctrl bit0 = long_open; other ctrl bits are reserved and read as 0.
- window=0 is treated as 1. ovr_err clears only on rst or on a start that is accepted.
- IDLE:
  - start with echo_num=0 -> done pulses next cycle; stay IDLE.
  - start with echo_num≠0 -> ARMED; echo_idx=0; ovr_err cleared.
- ARMED: echo_trig -> DELAY, counter loaded with delay. If delay=0, go directly to OPEN.
- Latency: echo_trig at cycle t -> acq_en high from t+1+delay for exactly window cycles (normal mode).
- DELAY: counter counts down; reaching 0 -> OPEN. echo_trig in DELAY sets ovr_err and is otherwise ignored.
- OPEN, normal mode (long_open=0):
  - acq_en=1 for window cycles; at the last cycle echo_idx increments.
  - If echo_idx+1 = echo_num -> IDLE with done pulse on the following cycle; else -> ARMED.
  - echo_trig in OPEN sets ovr_err and is ignored.
- OPEN, long_open=1:
  - The window stays open until the next echo_trig. That trig closes the window (acq_en low next cycle), increments echo_idx, and starts the next echo's DELAY.
  - The final echo (echo_idx = echo_num-1) closes after window cycles -> IDLE, done.
- acq_en is registered and glitch-free. It is high only in OPEN.
- abort (any state) has highest priority over same-cycle echo_trig/start. Next cycle: IDLE, acq_en=0, echo_idx=0, no done pulse; ovr_err unchanged.
- start while busy is ignored.
- Simultaneous window end and echo_trig (normal mode): the window completes normally and echo_trig sets ovr_err.
- Counters saturate; no wrap. echo_idx never exceeds echo_num.

Optional Feature:
- Macro ACQ_TIMEOUT_EN.
- Defined:
  - Adds output port tmo_err (1 bit, sticky, cleared by rst or an accepted start).
  - A watchdog counts cycles spent in ARMED. Reaching TMO_CYC -> tmo_err=1 and IDLE with no done pulse.
  - The watchdog reloads on every entry to ARMED.
- Undefined: no tmo_err port; ARMED waits indefinitely.

Test Plan:
- Reset defaults: load delay=5, window=8, echo_num=3; start; echo_trig at t0, t0+40, t0+80 -> acq_en high t0+6..t0+13 (and the same offsets for the other two echoes); echo_idx 1,2,3; done single pulse after the third window; busy falls with it.
- delay=0, window=0 -> acq_en high exactly 1 cycle at t+1 per trig.
- Overrun: delay=10, echo_trig at t and t+4 -> ovr_err=1 from t+5; only one window opens (t+11..).
- long_open=1, echo_num=2, window=4, trigs at t and t+30 -> acq_en high t+1..t+30 then t+31+delay for 4 cycles; done pulses.
- abort during OPEN (window=20, abort on cycle 5 of window) -> acq_en=0 next cycle, echo_idx=0, no done; a cfg write then succeeds; start with echo_num=0 -> done pulse, busy stays 0.
- With ACQ_TIMEOUT_EN, TMO_CYC=100: start, no echo_trig -> tmo_err=1 and busy=0 at cycle 101 after ARMED entry; a trig at cycle 99 prevents the timeout.

Source files
------------

// File: rtl/sd_acq_echo_sched.sv
// sd_acq_echo_sched: CPMG spin-echo acquisition window sequencer; optional ARMED watchdog enabled by macro ACQ_TIMEOUT_EN
module sd_acq_echo_sched #(
    parameter int CNT_W   = 16,
    parameter int ECHO_W  = 12,
    parameter int TMO_CYC = 1000000
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              cfg_load,
    input  logic [3:0]        cfg_sel,
    input  logic [CNT_W-1:0]  cfg_data,
    input  logic              start,
    input  logic              echo_trig,
    input  logic              abort,
    output logic              acq_en,
    output logic [ECHO_W-1:0] echo_idx,
    output logic              busy,
    output logic              done,
`ifdef ACQ_TIMEOUT_EN
    output logic              tmo_err,
`endif
    output logic              ovr_err
);
    typedef enum logic [1:0] {IDLE, ARMED, DELAY, OPEN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  delay_q, delay_d;
    logic [CNT_W-1:0]  window_q, window_d;
    logic [ECHO_W-1:0] echo_num_q, echo_num_d;
    logic              long_q, long_d;
    logic [ECHO_W-1:0] echo_idx_q, echo_idx_d;
    logic              acq_en_q, acq_en_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic [CNT_W-1:0]  win_eff;
    logic              last_echo;
    state_t            go_state;
    logic [CNT_W-1:0]  go_cnt;

`ifdef ACQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TMO_CYC + 1);
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              tmo_q, tmo_d;
`else
    // watchdog limit has no effect without the timeout feature
    localparam int unused_tmo_cyc = TMO_CYC;
`endif

    // a zero window still opens for one cycle
    assign win_eff   = (window_q == '0) ? CNT_W'(1) : window_q;
    // the echo currently being acquired is the last of the train
    assign last_echo = (echo_idx_q == echo_num_q - ECHO_W'(1));
    // a trig either starts the delay countdown or, with no delay, opens the window at once
    assign go_state  = (delay_q == '0) ? OPEN : DELAY;
    assign go_cnt    = (delay_q == '0) ? win_eff : delay_q;

    // next-state, config bank and counter update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        delay_d    = delay_q;
        window_d   = window_q;
        echo_num_d = echo_num_q;
        long_d     = long_q;
        echo_idx_d = echo_idx_q;
        ovr_d      = ovr_q;
        done_d     = 1'b0;
`ifdef ACQ_TIMEOUT_EN
        wd_d       = '0;
        tmo_d      = tmo_q;
`endif
        if (cfg_load && state_q == IDLE) begin
            delay_d    = (cfg_sel == 4'd0) ? cfg_data : delay_q;
            window_d   = (cfg_sel == 4'd1) ? cfg_data : window_q;
            echo_num_d = (cfg_sel == 4'd2) ? cfg_data[ECHO_W-1:0] : echo_num_q;
            long_d     = (cfg_sel == 4'd3) ? cfg_data[0] : long_q;
        end
        if (abort) begin
            state_d    = IDLE;
            echo_idx_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && echo_num_q == '0) begin
                        done_d = 1'b1;
                    end else if (start) begin
                        state_d    = ARMED;
                        echo_idx_d = '0;
                        ovr_d      = 1'b0;
`ifdef ACQ_TIMEOUT_EN
                        tmo_d      = 1'b0;
`endif
                    end
                end
                ARMED: begin
                    if (echo_trig) begin
                        state_d = go_state;
                        cnt_d   = go_cnt;
                    end
`ifdef ACQ_TIMEOUT_EN
                    else if (wd_q == WD_W'(TMO_CYC - 1)) begin
                        state_d = IDLE;
                        tmo_d   = 1'b1;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
`endif
                end
                DELAY: begin
                    ovr_d = ovr_q | echo_trig;
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = OPEN;
                        cnt_d   = win_eff;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    if (long_q && !last_echo) begin
                        if (echo_trig) begin
                            echo_idx_d = echo_idx_q + 1'b1;
                            state_d    = go_state;
                            cnt_d      = go_cnt;
                        end
                    end else begin
                        ovr_d = ovr_q | echo_trig;
                        if (cnt_q <= CNT_W'(1)) begin
                            echo_idx_d = echo_idx_q + 1'b1;
                            state_d    = last_echo ? IDLE : ARMED;
                            done_d     = last_echo;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
            endcase
        end
        acq_en_d = (state_d == OPEN);
    end

    // state and output registers
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            delay_q    <= '0;
            window_q   <= CNT_W'(16);
            echo_num_q <= ECHO_W'(1);
            long_q     <= 1'b0;
            echo_idx_q <= '0;
            acq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef ACQ_TIMEOUT_EN
            wd_q       <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            delay_q    <= delay_d;
            window_q   <= window_d;
            echo_num_q <= echo_num_d;
            long_q     <= long_d;
            echo_idx_q <= echo_idx_d;
            acq_en_q   <= acq_en_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
`ifdef ACQ_TIMEOUT_EN
            wd_q       <= wd_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign acq_en   = acq_en_q;
    assign echo_idx = echo_idx_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign ovr_err  = ovr_q;
`ifdef ACQ_TIMEOUT_EN
    assign tmo_err  = tmo_q;
`endif
endmodule
